// File: rtl/dma_cmd_scheduler.sv
// Descriptor FIFO and one-at-a-time issue sequencer feeding the DMA engine.
// Retires on engine completion or timeout and counts completed transfers.
module dma_cmd_scheduler #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        desc_valid,
    output logic                        desc_ready,
    input  logic [31:0]                 desc_src,
    input  logic [31:0]                 desc_dst,
    input  logic [LEN_W-1:0]            desc_len,
    output logic                        dma_start,
    output logic [31:0]                 dma_src,
    output logic [31:0]                 dma_dst,
    output logic [LEN_W-1:0]            dma_len,
    input  logic                        dma_ready,
    input  logic                        dma_done,
    output logic [$clog2(DEPTH):0]      queue_count,
    output logic                        busy,
    output logic [15:0]                 done_count,
    output logic                        err_timeout,
    input  logic                        err_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    typedef struct packed {
        logic [31:0]      src;
        logic [31:0]      dst;
        logic [LEN_W-1:0] len;
    } desc_t;

    desc_t           mem [DEPTH];
    desc_t           head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [TW-1:0]   tmr;
    logic [TW-1:0]   tmr_inc;
    logic [1:0]      state;
    logic [1:0]      state_n;
    logic            push;
    logic            pop;
    logic            issue;
    logic            retire_ok;
    logic            timeout_hit;

    assign head        = mem[rd_ptr];
    assign desc_ready  = (count < CW'(DEPTH));
    assign push        = desc_valid && desc_ready;
    assign queue_count = count;
    assign tmr_inc     = tmr + TW'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and retire/issue decisions; the head is popped only at retire
    always_comb begin
        state_n     = state;
        pop         = 1'b0;
        issue       = 1'b0;
        retire_ok   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    if (head.len == '0) begin
                        pop       = 1'b1;
                        retire_ok = 1'b1;
                    end else if (dma_ready) begin
                        issue   = 1'b1;
                        state_n = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (dma_done) begin
                    pop       = 1'b1;
                    retire_ok = 1'b1;
                    state_n   = S_IDLE;
                end else begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dma_done) begin
                    pop       = 1'b1;
                    retire_ok = 1'b1;
                    state_n   = S_IDLE;
                end else if (tmr_inc == TW'(TIMEOUT - 1)) begin
                    pop         = 1'b1;
                    timeout_hit = 1'b1;
                    state_n     = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{src: desc_src, dst: desc_dst, len: desc_len};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue outputs, timeout timer, status counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dma_start   <= 1'b0;
            dma_src     <= '0;
            dma_dst     <= '0;
            dma_len     <= '0;
            busy        <= 1'b0;
            tmr         <= '0;
            done_count  <= '0;
            err_timeout <= 1'b0;
        end else begin
            dma_start <= issue;
            busy      <= (state_n != S_IDLE);
            if (issue) begin
                dma_src <= head.src;
                dma_dst <= head.dst;
                dma_len <= head.len;
                tmr     <= '0;
            end else if (state == S_WAIT) begin
                tmr <= tmr_inc;
            end
            if (retire_ok) begin
                done_count <= done_count + 16'd1;
            end
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dma_cmd_scheduler.sv
// Directed bench for dma_cmd_scheduler: issue order, backpressure, zero-length, timeout, reset.
module tb_dma_cmd_scheduler;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned LEN_W   = 16;
    localparam int unsigned TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              desc_valid;
    logic              desc_ready;
    logic [31:0]       desc_src;
    logic [31:0]       desc_dst;
    logic [LEN_W-1:0]  desc_len;
    logic              dma_start;
    logic [31:0]       dma_src;
    logic [31:0]       dma_dst;
    logic [LEN_W-1:0]  dma_len;
    logic              dma_ready;
    logic              dma_done;
    logic [2:0]        queue_count;
    logic              busy;
    logic [15:0]       done_count;
    logic              err_timeout;
    logic              err_clr;

    int total = 0;
    int bad   = 0;

    dma_cmd_scheduler #(.DEPTH(DEPTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len),
        .dma_start(dma_start), .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len),
        .dma_ready(dma_ready), .dma_done(dma_done),
        .queue_count(queue_count), .busy(busy), .done_count(done_count),
        .err_timeout(err_timeout), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        desc_valid = 1'b0;
        desc_src   = '0;
        desc_dst   = '0;
        desc_len   = '0;
        dma_ready  = 1'b0;
        dma_done   = 1'b0;
        err_clr    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        desc_valid = 1'b1;
        desc_src   = s;
        desc_dst   = d;
        desc_len   = l;
        tick();
        desc_valid = 1'b0;
    endtask

    // Raise dma_ready, answer each start with dma_done 3 cycles later, check order and spacing
    task automatic run_drain(input string tag, input int n, input logic [31:0] srcs [3]);
        int cyc     = 0;
        int k       = 0;
        int done_at = -1;
        int last    = -100;
        dma_ready = 1'b1;
        while ((k < n || cyc <= done_at) && cyc < 80) begin
            tick();
            cyc++;
            if (dma_start) begin
                if (k < n) chk({tag, "_src"}, 64'(dma_src), 64'(srcs[k]));
                if (k == 0) chk({tag, "_first_lat"}, 64'(cyc), 64'd1);
                else        chk({tag, "_spacing_ge5"}, 64'(cyc - last >= 5), 64'd1);
                last    = cyc;
                done_at = cyc + 3;
                k++;
            end
            dma_done = (cyc == done_at);
        end
        dma_done = 1'b0;
        chk({tag, "_starts"}, 64'(k), 64'(n));
    endtask

    initial begin
        logic [31:0] srcs [3];
        logic        seen;

        // Reset state, sampled while rst_n is low
        rst_n = 1'b0; desc_valid = 1'b0; desc_src = '0; desc_dst = '0; desc_len = '0;
        dma_ready = 1'b0; dma_done = 1'b0; err_clr = 1'b0;
        tick();
        chk("rst_count", 64'(queue_count), 64'd0);
        chk("rst_ready", 64'(desc_ready), 64'd1);
        chk("rst_start", 64'(dma_start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done_count), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        chk("rst_src", 64'(dma_src), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single descriptor: issue latency and retire
        dma_ready = 1'b1;
        push(32'h1000, 32'h0, 16'd128);
        chk("t1_count", 64'(queue_count), 64'd1);
        chk("t1_nostart", 64'(dma_start), 64'd0);
        tick();
        chk("t1_start", 64'(dma_start), 64'd1);
        chk("t1_src", 64'(dma_src), 64'h1000);
        chk("t1_len", 64'(dma_len), 64'd128);
        chk("t1_busy", 64'(busy), 64'd1);
        tick();
        chk("t1_pulse_end", 64'(dma_start), 64'd0);
        repeat (8) tick();
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        chk("t1_done_count", 64'(done_count), 64'd1);
        chk("t1_count_end", 64'(queue_count), 64'd0);
        chk("t1_busy_end", 64'(busy), 64'd0);

        // Back-to-back pushes into a full queue
        do_reset();
        dma_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            desc_valid = 1'b1;
            desc_src   = 32'h2000 + 32'(i);
            desc_dst   = 32'h0;
            desc_len   = 16'd4;
            chk("t2_ready", 64'(desc_ready), 64'(i < 4));
            tick();
        end
        chk("t2_full_count", 64'(queue_count), 64'd4);
        chk("t2_full_ready", 64'(desc_ready), 64'd0);
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        chk("t2_after_done", 64'(queue_count), 64'd3);
        chk("t2_ready_again", 64'(desc_ready), 64'd1);
        tick();
        desc_valid = 1'b0;
        chk("t2_fifth_in", 64'(queue_count), 64'd4);

        // dma_ready gating then FIFO-order drain
        do_reset();
        push(32'hA0, 32'h1, 16'd1);
        push(32'hA1, 32'h2, 16'd2);
        push(32'hA2, 32'h3, 16'd3);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | dma_start;
        end
        chk("t4_no_start", 64'(seen), 64'd0);
        chk("t4_count", 64'(queue_count), 64'd3);
        srcs[0] = 32'hA0; srcs[1] = 32'hA1; srcs[2] = 32'hA2;
        run_drain("t3", 3, srcs);
        chk("t3_done_count", 64'(done_count), 64'd3);
        chk("t3_count_end", 64'(queue_count), 64'd0);

        // Push in the same cycle as a retire keeps count unchanged
        push(32'hB0, 32'h0, 16'd9);
        tick();
        tick();
        desc_valid = 1'b1; desc_src = 32'hB1; desc_len = 16'd9;
        dma_done   = 1'b1;
        tick();
        desc_valid = 1'b0;
        dma_done   = 1'b0;
        chk("t3_pushpop_count", 64'(queue_count), 64'd1);
        chk("t3_pushpop_done", 64'(done_count), 64'd4);

        // Zero-length descriptor between two normal ones
        do_reset();
        push(32'h10, 32'h0, 16'd4);
        push(32'h20, 32'h0, 16'd0);
        push(32'h30, 32'h0, 16'd8);
        srcs[0] = 32'h10; srcs[1] = 32'h30; srcs[2] = 32'h0;
        run_drain("t5", 2, srcs);
        chk("t5_done_count", 64'(done_count), 64'd3);
        chk("t5_count_end", 64'(queue_count), 64'd0);

        // Timeout with no dma_done
        do_reset();
        dma_ready = 1'b1;
        push(32'h40, 32'h0, 16'd5);
        tick();
        chk("t6_start", 64'(dma_start), 64'd1);
        repeat (TIMEOUT - 1) tick();
        chk("t6_err_early", 64'(err_timeout), 64'd0);
        chk("t6_busy_early", 64'(busy), 64'd1);
        tick();
        chk("t6_err", 64'(err_timeout), 64'd1);
        chk("t6_dropped", 64'(queue_count), 64'd0);
        chk("t6_done_same", 64'(done_count), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t6_err_clr", 64'(err_timeout), 64'd0);

        // Reset in the middle of WAIT discards the queue
        push(32'h50, 32'h0, 16'd5);
        push(32'h60, 32'h0, 16'd5);
        tick();
        tick();
        chk("t7_busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t7_count", 64'(queue_count), 64'd0);
        chk("t7_start", 64'(dma_start), 64'd0);
        chk("t7_ready", 64'(desc_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | dma_start;
        end
        chk("t7_no_restart", 64'(seen), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
